// File: rtl/decrypter.sv
// Receive-side decrypter: regenerates the keystream from a programmed key and the per-word
// rotation, XORs it off the cipher word, and queues plaintext for the collector.
module decrypter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ROT_WIDTH  = 5,
  parameter int unsigned ADV        = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in_p,
  input  logic [ROT_WIDTH-1:0] key_rotation_p,
  input  logic                 prog_p,
  input  logic                 data_ready_in_p,
  output logic                 ready_p,
  output logic [WIDTH-1:0]     data_out_c,
  output logic                 data_ready_out_c,
  input  logic                 capture_c,
  output logic                 key_loaded,
  output logic [15:0]          decrypt_count
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned ProdW = (2 * WIDTH > 64) ? 2 * WIDTH : 64;
  localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [ProdW-1:0] ModC = ProdW'(64'd4294967311);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]     key_q;
  logic                 key_loaded_q;

  logic                 stage_valid_q;
  logic [WIDTH-1:0]     stage_data_q;
  logic [ROT_WIDTH-1:0] stage_rot_q;
  logic [WIDTH-1:0]     stage_key_q;

  logic [WIDTH-1:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      fifo_cnt_q, fifo_cnt_d;

  logic [15:0]          decrypt_count_q;
  logic [15:0]          decrypt_count_d;

  logic                 accept, push, pop, fifo_empty;
  logic [CntW:0]        occupancy;

  logic [4:0]           adv_x;
  logic [WIDTH-1:0]     adv_kn, adv_kr, ks_basic, ks_adv, keystream, plaintext;
  logic [ProdW-1:0]     adv_prod, adv_mod;
  int unsigned          rot_mod;

  // Left rotate; amt must already be reduced below WIDTH.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int unsigned amt);
    logic [2*WIDTH-1:0] dbl;
    dbl = {v, v} << amt;
    return dbl[2*WIDTH-1:WIDTH];
  endfunction

  // Next state: the first key load starts the run; later loads just replace the key.
  always_comb begin
    state_d = state_q;
    if (prog_p) state_d = StRun;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Key register; a load takes precedence over any word offered on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q        <= '0;
      key_loaded_q <= 1'b0;
    end else if (prog_p) begin
      key_q        <= data_in_p;
      key_loaded_q <= 1'b1;
    end
  end

  // Stage occupancy counts toward the FIFO so an accepted word always has a slot next edge.
  always_comb begin
    occupancy  = {1'b0, fifo_cnt_q} + (CntW + 1)'(stage_valid_q);
    ready_p    = (state_q == StRun) && (occupancy < DepthC);
    accept     = data_ready_in_p && ready_p && !prog_p;
    fifo_empty = (fifo_cnt_q == '0);
    push       = stage_valid_q;
    pop        = capture_c && !fifo_empty;
  end

  // Input stage: cipher, rotation and a snapshot of the key in force at accept time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      stage_rot_q   <= '0;
      stage_key_q   <= '0;
    end else begin
      stage_valid_q <= accept;
      if (accept) begin
        stage_data_q <= data_in_p;
        stage_rot_q  <= key_rotation_p;
        stage_key_q  <= key_q;
      end
    end
  end

  // Keystream regeneration from the staged key snapshot, then XOR back to plaintext.
  always_comb begin
    rot_mod   = 32'(stage_rot_q) % WIDTH;
    ks_basic  = rotl(stage_key_q, rot_mod);
    adv_x     = stage_key_q[4:0] ^ 5'(stage_rot_q);
    adv_kn    = stage_key_q ^ (WIDTH'(adv_x) << 27);
    adv_kr    = rotl(adv_kn, 32'(adv_x) % WIDTH);
    adv_prod  = ProdW'(adv_kr) * ProdW'(adv_kr);
    adv_mod   = adv_prod % ModC;
    ks_adv    = adv_mod[WIDTH-1:0];
    keystream = (ADV != 0) ? ks_adv : ks_basic;
    plaintext = stage_data_q ^ keystream;
  end

  // FIFO storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= plaintext;
  end

  // FIFO occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
  end

  // FIFO pointers and count; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign decrypt_count_d = pop ? decrypt_count_q + 16'd1 : decrypt_count_q;

  // Words-delivered counter; wraps at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) decrypt_count_q <= '0;
    else        decrypt_count_q <= decrypt_count_d;
  end

  // Head is gated by empty so outputs read zero as soon as reset clears the count.
  always_comb begin
    data_out_c       = fifo_empty ? '0 : mem_q[rd_ptr_q];
    data_ready_out_c = !fifo_empty;
    key_loaded       = key_loaded_q;
    decrypt_count    = decrypt_count_q;
  end

endmodule

// File: tb/tb_decrypter.sv
// Bench for decrypter: one basic and one ADV instance, table vectors plus stream sequences.
module tb_decrypter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din  [2];
  logic [4:0]  rot  [2];
  logic        prog [2];
  logic        dv   [2];
  logic        cap  [2];
  logic        rdy  [2];
  logic        rdo  [2];
  logic        kl   [2];
  logic [31:0] dout [2];
  logic [15:0] cnt  [2];

  int nvec  = 0;
  int nfail = 0;
  logic [15:0] exp_cnt [2];

  always #5 clk = ~clk;

  decrypter #(.WIDTH(32), .ROT_WIDTH(5), .ADV(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .data_in_p(din[0]), .key_rotation_p(rot[0]), .prog_p(prog[0]),
    .data_ready_in_p(dv[0]), .ready_p(rdy[0]), .data_out_c(dout[0]),
    .data_ready_out_c(rdo[0]), .capture_c(cap[0]), .key_loaded(kl[0]),
    .decrypt_count(cnt[0])
  );

  decrypter #(.WIDTH(32), .ROT_WIDTH(5), .ADV(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .data_in_p(din[1]), .key_rotation_p(rot[1]), .prog_p(prog[1]),
    .data_ready_in_p(dv[1]), .ready_p(rdy[1]), .data_out_c(dout[1]),
    .data_ready_out_c(rdo[1]), .capture_c(cap[1]), .key_loaded(kl[1]),
    .decrypt_count(cnt[1])
  );

  typedef struct {
    int          sel;
    logic [31:0] key;
    logic [4:0]  r;
    logic [31:0] cipher;
    logic [31:0] plain;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit-serial rotate, independent of the RTL's doubled-word approach.
  function automatic logic [31:0] m_rotl(input logic [31:0] v, input int n);
    logic [31:0] t;
    t = v;
    for (int i = 0; i < n; i++) t = {t[30:0], t[31]};
    return t;
  endfunction

  function automatic logic [31:0] m_ks(input int sel, input logic [31:0] key,
                                       input logic [4:0] r);
    logic [4:0]  x;
    logic [31:0] kn, kr;
    logic [63:0] sq, md;
    if (sel == 0) return m_rotl(key, int'(r));
    x  = key[4:0] ^ r;
    kn = key ^ {x, 27'd0};
    kr = m_rotl(kn, int'(x));
    sq = {32'd0, kr} * {32'd0, kr};
    md = sq % 64'd4294967311;
    return md[31:0];
  endfunction

  task automatic prog_key(input int s, input logic [31:0] k);
    din[s]  = k;
    prog[s] = 1'b1;
    tick();
    prog[s] = 1'b0;
    chk("key_loaded", {31'd0, kl[s]}, 32'd1);
    chk("ready_after_prog", {31'd0, rdy[s]}, 32'd1);
  endtask

  // Random plaintext stream with random capture back-pressure, scoreboarded in order.
  task automatic stream(input int s, input int n, input logic [31:0] key);
    logic [31:0] pl [128];
    logic [4:0]  rr [128];
    logic [31:0] q [$];
    int sent = 0;
    int cyc  = 0;
    logic acc, pp;
    for (int i = 0; i < n; i++) begin
      pl[i] = $urandom;
      rr[i] = (i == 0) ? 5'd0 : (i == 1) ? 5'd31 : 5'($urandom_range(0, 31));
    end
    while ((sent < n || q.size() > 0) && cyc < 2000) begin
      dv[s]  = (sent < n);
      if (sent < n) begin
        din[s] = pl[sent] ^ m_ks(s, key, rr[sent]);
        rot[s] = rr[sent];
      end
      cap[s] = ($urandom_range(0, 3) != 0);
      acc = dv[s] && rdy[s];
      pp  = cap[s] && rdo[s];
      if (pp) begin
        if (q.size() > 0) begin
          chk($sformatf("stream%0d_word", s), dout[s], q[0]);
          void'(q.pop_front());
          exp_cnt[s]++;
        end else begin
          chk($sformatf("stream%0d_extra", s), {31'd0, rdo[s]}, 32'd0);
        end
      end
      tick();
      if (acc) begin
        q.push_back(pl[sent]);
        sent++;
      end
      cyc++;
    end
    dv[s]  = 1'b0;
    cap[s] = 1'b0;
    chk($sformatf("stream%0d_sent", s), sent, n);
    chk($sformatf("stream%0d_drained", s), q.size(), 0);
    chk($sformatf("stream%0d_count", s), {16'd0, cnt[s]}, {16'd0, exp_cnt[s]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] w [6];
    int sent, got;
    logic acc;

    vt[0] = '{0, 32'hDEADBEEF, 5'd4,  32'hF8EFB885, 32'h12345678};
    vt[1] = '{0, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 32'h00000000};
    vt[2] = '{0, 32'h80000001, 5'd1,  32'hFFFFFFFF, 32'hFFFFFFFC};
    vt[3] = '{0, 32'h00000001, 5'd31, 32'h80000001, 32'h00000001};
    vt[4] = '{0, 32'h12345678, 5'd8,  32'h00000000, 32'h34567812};
    vt[5] = '{0, 32'hF0F0F0F0, 5'd16, 32'h0F0F0F0F, 32'hFFFFFFFF};
    vt[6] = '{1, 32'h00000000, 5'd0,  32'h12345678, 32'h12345678};
    vt[7] = '{1, 32'h00000000, 5'd1,  32'hF100000F, 32'h00000000};
    vt[8] = '{1, 32'h00000000, 5'd2,  32'h1000FFF0, 32'h0000FFFF};

    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      din[s] = '0; rot[s] = '0; prog[s] = 1'b0; dv[s] = 1'b0; cap[s] = 1'b0;
      exp_cnt[s] = '0;
    end
    #2;
    chk("rst_ready", {31'd0, rdy[0]}, 32'd0);
    chk("rst_out", dout[0], 32'd0);
    chk("rst_ready_out", {31'd0, rdo[0]}, 32'd0);
    chk("rst_key_loaded", {31'd0, kl[0]}, 32'd0);
    chk("rst_count", {16'd0, cnt[0]}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("idle_ready", {31'd0, rdy[0]}, 32'd0);
    dv[0] = 1'b1;
    din[0] = 32'hCAFEF00D;
    tick(); tick(); tick();
    chk("idle_no_accept", {31'd0, rdo[0]}, 32'd0);
    dv[0] = 1'b0;

    // Table vectors: single word through the two-edge pipeline, then one capture.
    for (int i = 0; i < 9; i++) begin
      int s;
      s = vt[i].sel;
      prog_key(s, vt[i].key);
      din[s] = vt[i].cipher;
      rot[s] = vt[i].r;
      dv[s]  = 1'b1;
      tick();
      dv[s] = 1'b0;
      chk($sformatf("vec%0d_lat1", i), {31'd0, rdo[s]}, 32'd0);
      tick();
      chk($sformatf("vec%0d_valid", i), {31'd0, rdo[s]}, 32'd1);
      chk($sformatf("vec%0d_plain", i), dout[s], vt[i].plain);
      cap[s] = 1'b1;
      tick();
      cap[s] = 1'b0;
      exp_cnt[s]++;
      chk($sformatf("vec%0d_count", i), {16'd0, cnt[s]}, {16'd0, exp_cnt[s]});
      chk($sformatf("vec%0d_empty", i), {31'd0, rdo[s]}, 32'd0);
    end

    // Random streams through both keystream flavours.
    prog_key(0, 32'h5A17C3E9);
    stream(0, 100, 32'h5A17C3E9);
    prog_key(1, 32'h9E3779B9);
    stream(1, 100, 32'h9E3779B9);

    // Fill with capture low, then drain one pop per cycle while the rest arrive.
    prog_key(0, 32'hDEADBEEF);
    for (int i = 0; i < 6; i++) w[i] = 32'h1000_0000 + i;
    sent = 0;
    for (int c = 0; c < 4; c++) begin
      dv[0]  = (sent < 6);
      din[0] = w[sent] ^ m_ks(0, 32'hDEADBEEF, 5'(sent));
      rot[0] = 5'(sent);
      acc = dv[0] && rdy[0];
      tick();
      if (acc) sent++;
    end
    chk("fill_accepts", sent, 4);
    chk("fill_ready_low", {31'd0, rdy[0]}, 32'd0);
    chk("fill_head", dout[0], w[0]);
    got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      dv[0] = (sent < 6);
      if (sent < 6) begin
        din[0] = w[sent] ^ m_ks(0, 32'hDEADBEEF, 5'(sent));
        rot[0] = 5'(sent);
      end
      cap[0] = 1'b1;
      acc = dv[0] && rdy[0];
      if (rdo[0]) begin
        chk($sformatf("drain_word%0d", got), dout[0], w[got]);
        got++;
        exp_cnt[0]++;
      end
      tick();
      if (acc) sent++;
    end
    dv[0] = 1'b0;
    chk("drain_got", got, 6);
    chk("drain_count", {16'd0, cnt[0]}, {16'd0, exp_cnt[0]});
    tick(); tick();
    chk("empty_capture_count", {16'd0, cnt[0]}, {16'd0, exp_cnt[0]});
    chk("empty_capture_ready", {31'd0, rdo[0]}, 32'd0);
    cap[0] = 1'b0;

    // Key reload alongside an offered word; in-flight word keeps its old key.
    din[0] = 32'hF8EFB885; rot[0] = 5'd4; dv[0] = 1'b1;
    tick();
    din[0] = 32'h00000001; prog[0] = 1'b1;
    tick();
    prog[0] = 1'b0;
    din[0] = 32'hAAAA5545;
    chk("rekey_old_word", dout[0], 32'h12345678);
    tick();
    dv[0] = 1'b0;
    tick();
    chk("rekey_head", dout[0], 32'h12345678);
    cap[0] = 1'b1;
    tick();
    chk("rekey_new_word", dout[0], 32'hAAAA5555);
    tick();
    cap[0] = 1'b0;
    exp_cnt[0] += 16'd2;
    chk("rekey_no_extra", {31'd0, rdo[0]}, 32'd0);
    chk("rekey_count", {16'd0, cnt[0]}, {16'd0, exp_cnt[0]});

    // Reset with three words buffered.
    for (int i = 0; i < 3; i++) begin
      din[0] = 32'h0BAD_0000 + i; rot[0] = 5'd0; dv[0] = 1'b1;
      tick();
    end
    dv[0] = 1'b0;
    tick(); tick();
    chk("pre_reset_valid", {31'd0, rdo[0]}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    exp_cnt[0] = '0;
    exp_cnt[1] = '0;
    chk("async_rst_out", dout[0], 32'd0);
    chk("async_rst_ready_out", {31'd0, rdo[0]}, 32'd0);
    chk("async_rst_ready", {31'd0, rdy[0]}, 32'd0);
    chk("async_rst_key_loaded", {31'd0, kl[0]}, 32'd0);
    chk("async_rst_count", {16'd0, cnt[0]}, 32'd0);
    chk("async_rst_count1", {16'd0, cnt[1]}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, rdy[0]}, 32'd0);
    dv[0] = 1'b1; din[0] = 32'h1234_0000;
    tick(); tick(); tick();
    dv[0] = 1'b0;
    chk("post_rst_no_word", {31'd0, rdo[0]}, 32'd0);

    // Counter wrap: preload 0xFFFF through the next-count path, then pop one word.
    prog_key(0, 32'hDEADBEEF);
    din[0] = 32'hDEADBEEF; rot[0] = 5'd0; dv[0] = 1'b1;
    tick();
    dv[0] = 1'b0;
    tick();
    force dut0.decrypt_count_d = 16'hFFFF;
    tick();
    release dut0.decrypt_count_d;
    chk("wrap_preload", {16'd0, cnt[0]}, 32'h0000FFFF);
    chk("wrap_head", dout[0], 32'h00000000);
    cap[0] = 1'b1;
    tick();
    cap[0] = 1'b0;
    chk("wrap_count", {16'd0, cnt[0]}, 32'd0);
    chk("wrap_empty", {31'd0, rdo[0]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
